counter_locator: RTL and testbench

- Sequential successor to the single-wall counter check. For a requested facing direction (right, left, up, down), it decides whether the penguin is touching that wall's counter row.
- When touching, it returns the centre of the nearest counter tile.
- Tile size, wall thresholds and clamps are parameters. The modulo is computed iteratively by repeated subtraction (no combinational `%`).
- Sits between the penguin motion logic and the item pick-up/drop logic. Runs on request with a start/valid handshake.

---
 rtl/counter_locator.sv | 172 +++++++++++++++++
 tb/tb_counter_locator.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/counter_locator.sv
// Counter locator: for a requested facing direction, reports whether the penguin touches
// that wall's counter row and, if so, the centre of the nearest counter tile.
module counter_locator #(
  parameter int COORD_W   = 10,
  parameter int TILE      = 40,
  parameter int RIGHT_TH  = 540,
  parameter int RIGHT_CTR = 580,
  parameter int LEFT_TH   = 100,
  parameter int LEFT_CTR  = 60,
  parameter int TOP_TH    = 100,
  parameter int TOP_CTR   = 60,
  parameter int BOT_TH    = 380,
  parameter int BOT_CTR   = 420,
  parameter int Y_LO      = 140,
  parameter int Y_LO_CTR  = 140,
  parameter int Y_HI      = 300,
  parameter int Y_HI_CTR  = 340,
  parameter int X_LO      = 140,
  parameter int X_LO_CTR  = 140,
  parameter int X_HI      = 500,
  parameter int X_HI_CTR  = 540
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               start,
  input  logic [1:0]         dir,
  input  logic [COORD_W-1:0] penguinX,
  input  logic [COORD_W-1:0] penguinY,
  output logic               ready,
  output logic               valid,
  output logic               touchingFlag,
  output logic [COORD_W-1:0] nearestCounterX,
  output logic [COORD_W-1:0] nearestCounterY
);

  // state  | meaning
  // IDLE   | waiting for start, ready=1
  // CHECK  | wall test, clamp or load remainder
  // DIVIDE | repeated subtraction of TILE, snap on exit
  // DONE   | one-cycle valid strobe
  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_DIVIDE, S_DONE} state_t;

  localparam logic [COORD_W-1:0] P_TILE      = COORD_W'(TILE);
  localparam logic [COORD_W-1:0] P_HALF      = COORD_W'(TILE / 2);
  localparam logic [COORD_W-1:0] P_RIGHT_TH  = COORD_W'(RIGHT_TH);
  localparam logic [COORD_W-1:0] P_RIGHT_CTR = COORD_W'(RIGHT_CTR);
  localparam logic [COORD_W-1:0] P_LEFT_TH   = COORD_W'(LEFT_TH);
  localparam logic [COORD_W-1:0] P_LEFT_CTR  = COORD_W'(LEFT_CTR);
  localparam logic [COORD_W-1:0] P_TOP_TH    = COORD_W'(TOP_TH);
  localparam logic [COORD_W-1:0] P_TOP_CTR   = COORD_W'(TOP_CTR);
  localparam logic [COORD_W-1:0] P_BOT_TH    = COORD_W'(BOT_TH);
  localparam logic [COORD_W-1:0] P_BOT_CTR   = COORD_W'(BOT_CTR);
  localparam logic [COORD_W-1:0] P_Y_LO      = COORD_W'(Y_LO);
  localparam logic [COORD_W-1:0] P_Y_LO_CTR  = COORD_W'(Y_LO_CTR);
  localparam logic [COORD_W-1:0] P_Y_HI      = COORD_W'(Y_HI);
  localparam logic [COORD_W-1:0] P_Y_HI_CTR  = COORD_W'(Y_HI_CTR);
  localparam logic [COORD_W-1:0] P_X_LO      = COORD_W'(X_LO);
  localparam logic [COORD_W-1:0] P_X_LO_CTR  = COORD_W'(X_LO_CTR);
  localparam logic [COORD_W-1:0] P_X_HI      = COORD_W'(X_HI);
  localparam logic [COORD_W-1:0] P_X_HI_CTR  = COORD_W'(X_HI_CTR);

  state_t               r_state, w_next;
  logic [1:0]           r_dir;
  logic [COORD_W-1:0]   r_x, r_y, r_c, r_rem;
  logic                 r_flag;
  logic [COORD_W-1:0]   r_cx, r_cy;

  logic                 w_wall_is_x;
  logic                 w_touch;
  logic [COORD_W-1:0]   w_wall_ctr;
  logic [COORD_W-1:0]   w_c;
  logic [COORD_W-1:0]   w_lo, w_lo_ctr, w_hi, w_hi_ctr;
  logic                 w_clamp_lo, w_clamp_hi;
  logic                 w_rem_ge;
  logic [COORD_W-1:0]   w_snap;

  // Right/left walls are X walls, so their perpendicular axis is Y.
  assign w_wall_is_x = ~r_dir[1];

  always_comb begin
    w_touch    = 1'b0;
    w_wall_ctr = '0;
    case (r_dir)
      2'd0:    begin w_touch = (r_x >= P_RIGHT_TH); w_wall_ctr = P_RIGHT_CTR; end
      2'd1:    begin w_touch = (r_x <= P_LEFT_TH);  w_wall_ctr = P_LEFT_CTR;  end
      2'd2:    begin w_touch = (r_y <= P_TOP_TH);   w_wall_ctr = P_TOP_CTR;   end
      2'd3:    begin w_touch = (r_y >= P_BOT_TH);   w_wall_ctr = P_BOT_CTR;   end
      default: begin w_touch = 1'b0;                w_wall_ctr = '0;          end
    endcase
  end

  assign w_c        = w_wall_is_x ? r_y : r_x;
  assign w_lo       = w_wall_is_x ? P_Y_LO     : P_X_LO;
  assign w_lo_ctr   = w_wall_is_x ? P_Y_LO_CTR : P_X_LO_CTR;
  assign w_hi       = w_wall_is_x ? P_Y_HI     : P_X_HI;
  assign w_hi_ctr   = w_wall_is_x ? P_Y_HI_CTR : P_X_HI_CTR;
  assign w_clamp_lo = (w_c < w_lo);
  assign w_clamp_hi = (w_c >= w_hi);

  assign w_rem_ge = (r_rem >= P_TILE);
  assign w_snap   = (r_rem != '0) ? (r_c - r_rem + P_HALF) : (r_c - P_HALF);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_CHECK;
      S_CHECK:  w_next = (w_touch && !w_clamp_lo && !w_clamp_hi) ? S_DIVIDE : S_DONE;
      S_DIVIDE: if (!w_rem_ge) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_dir  <= '0;
      r_x    <= '0;
      r_y    <= '0;
      r_c    <= '0;
      r_rem  <= '0;
      r_flag <= 1'b0;
      r_cx   <= '0;
      r_cy   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dir <= dir;
            r_x   <= penguinX;
            r_y   <= penguinY;
          end
        end
        S_CHECK: begin
          if (!w_touch) begin
            r_flag <= 1'b0;
            r_cx   <= '0;
            r_cy   <= '0;
          end else if (w_clamp_lo || w_clamp_hi) begin
            r_flag <= 1'b1;
            r_cx   <= w_wall_is_x ? w_wall_ctr : (w_clamp_lo ? w_lo_ctr : w_hi_ctr);
            r_cy   <= w_wall_is_x ? (w_clamp_lo ? w_lo_ctr : w_hi_ctr) : w_wall_ctr;
          end else begin
            r_c   <= w_c;
            r_rem <= w_c;
          end
        end
        S_DIVIDE: begin
          if (w_rem_ge) begin
            r_rem <= r_rem - P_TILE;
          end else begin
            r_flag <= 1'b1;
            r_cx   <= w_wall_is_x ? w_wall_ctr : w_snap;
            r_cy   <= w_wall_is_x ? w_snap : w_wall_ctr;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready           = (r_state == S_IDLE);
  assign valid           = (r_state == S_DONE);
  assign touchingFlag    = r_flag;
  assign nearestCounterX = r_cx;
  assign nearestCounterY = r_cy;

endmodule

// File: tb/tb_counter_locator.sv
// Bench for counter_locator: directed cases plus randomized requests checked against
// an arithmetic reference model of the wall/clamp/snap rules.
module tb_counter_locator;

  localparam int W = 10;

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   dir = '0;
  logic [W-1:0] penguinX = '0;
  logic [W-1:0] penguinY = '0;
  logic         ready, valid, touchingFlag;
  logic [W-1:0] nearestCounterX, nearestCounterY;

  int n_vec = 0;
  int n_err = 0;

  counter_locator dut (
    .Clk(Clk), .Reset(Reset), .start(start), .dir(dir),
    .penguinX(penguinX), .penguinY(penguinY),
    .ready(ready), .valid(valid), .touchingFlag(touchingFlag),
    .nearestCounterX(nearestCounterX), .nearestCounterY(nearestCounterY)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: what the wall/clamp/snap rules say, with latency counted from the accept cycle.
  function automatic void model(input int d, input int x, input int y,
                                output int f, output int ex, output int ey, output int lat);
    int c, lo, lo_c, hi, hi_c, wctr, perp, r;
    bit touch, x_wall;
    x_wall = (d < 2);
    case (d)
      0: begin touch = (x >= 540); wctr = 580; end
      1: begin touch = (x <= 100); wctr = 60;  end
      2: begin touch = (y <= 100); wctr = 60;  end
      default: begin touch = (y >= 380); wctr = 420; end
    endcase
    if (!touch) begin
      f = 0; ex = 0; ey = 0; lat = 2;
      return;
    end
    f = 1;
    c = x_wall ? y : x;
    if (x_wall) begin lo = 140; lo_c = 140; hi = 300; hi_c = 340; end
    else        begin lo = 140; lo_c = 140; hi = 500; hi_c = 540; end
    if (c < lo)       begin perp = lo_c; lat = 2; end
    else if (c >= hi) begin perp = hi_c; lat = 2; end
    else begin
      r    = c % 40;
      perp = (r > 0) ? (c - r + 20) : (c - 20);
      lat  = 3 + c / 40;
    end
    ex = x_wall ? wctr : perp;
    ey = x_wall ? perp : wctr;
  endfunction

  task automatic req(input int d, input int x, input int y, input bit scramble, input string tag);
    int f, ex, ey, lat, n;
    model(d, x, y, f, ex, ey, lat);
    @(negedge Clk);
    n = 0;
    while (!ready && n < 50) begin @(negedge Clk); n++; end
    chk({tag, "_ready"}, int'(ready), 1);
    dir = 2'(d); penguinX = W'(x); penguinY = W'(y); start = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    start = 1'b0;
    n = 1;
    while (!valid && n < 100) begin
      if (scramble) begin
        dir = 2'($urandom_range(0, 3));
        penguinX = W'($urandom_range(0, 700));
        penguinY = W'($urandom_range(0, 480));
      end
      @(negedge Clk);
      n++;
    end
    chk({tag, "_latency"}, n, lat);
    chk({tag, "_flag"}, int'(touchingFlag), f);
    chk({tag, "_x"}, int'(nearestCounterX), ex);
    chk({tag, "_y"}, int'(nearestCounterY), ey);
    chk({tag, "_busy"}, int'(ready), 0);
    @(negedge Clk);
    chk({tag, "_strobe"}, int'(valid), 0);
    chk({tag, "_hold_x"}, int'(nearestCounterX), ex);
    chk({tag, "_hold_y"}, int'(nearestCounterY), ey);
  endtask

  initial begin
    int acc, vals, dbl, stale;
    bit prev_v;

    // Reset state
    #1;
    chk("rst_valid", int'(valid), 0);
    chk("rst_flag", int'(touchingFlag), 0);
    chk("rst_x", int'(nearestCounterX), 0);
    chk("rst_y", int'(nearestCounterY), 0);
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    #1;
    chk("rst_ready", int'(ready), 1);

    // Directed cases
    req(0, 560, 200, 0, "r_rem0");
    req(0, 540, 225, 0, "r_225");
    req(0, 540, 260, 0, "r_260");
    req(0, 540, 250, 0, "r_250");
    req(0, 600, 100, 0, "r_clamp_lo");
    req(0, 600, 300, 0, "r_clamp_hi");
    req(3, 310, 400, 0, "d_310");
    req(1, 101, 200, 0, "l_miss");
    req(1, 100, 139, 0, "l_edge");
    req(2, 499, 100, 1, "u_edge");
    req(2, 500, 50, 1, "u_clamp_hi");
    req(3, 140, 380, 1, "d_lo_edge");
    req(0, 539, 200, 1, "r_miss");

    // Randomized, inputs scrambled while busy
    for (int i = 0; i < 40; i++)
      req(int'($urandom_range(0, 3)), int'($urandom_range(0, 700)),
          int'($urandom_range(0, 480)), 1, "rand");

    // start held high: exactly one valid per accept, never two valids in a row
    @(negedge Clk);
    dir = 2'd0; penguinX = W'(600); penguinY = W'(100); start = 1'b1;
    acc = 0; vals = 0; dbl = 0; prev_v = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (ready && start) acc++;
      if (valid) vals++;
      if (valid && prev_v) dbl++;
      prev_v = valid;
      @(negedge Clk);
    end
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (valid) vals++;
      if (valid && prev_v) dbl++;
      prev_v = valid;
      @(negedge Clk);
    end
    chk("hold_accepts", acc, 10);
    chk("hold_valids", vals, acc);
    chk("hold_double", dbl, 0);
    chk("hold_y", int'(nearestCounterY), 140);

    // Reset while dividing: everything clears, no stale strobe afterwards
    req(0, 560, 200, 0, "pre_rst");
    @(negedge Clk);
    dir = 2'd0; penguinX = W'(560); penguinY = W'(260); start = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    start = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    #1;
    chk("mid_rst_valid", int'(valid), 0);
    chk("mid_rst_flag", int'(touchingFlag), 0);
    chk("mid_rst_x", int'(nearestCounterX), 0);
    chk("mid_rst_y", int'(nearestCounterY), 0);
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    chk("mid_rst_ready", int'(ready), 1);
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      if (valid) stale++;
    end
    chk("mid_rst_stale", stale, 0);
    req(3, 310, 400, 0, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
